// File: rtl/gpio_irqmode_pkg.sv
// Shared definitions for the gpio family of blocks.
//   - CSR register offsets relative to a block's BASE_ADDR (5-bit address space)
//   - Interrupt type encodings, formed per pin as {ITYPE_HI[i], ITYPE_LO[i]}
//   - pin_event(): turns a pin's filtered level history into an event for its mode
package gpio_irqmode_pkg;

    localparam logic [4:0] OFS_OE       = 5'd0;
    localparam logic [4:0] OFS_OUT      = 5'd1;
    localparam logic [4:0] OFS_IN       = 5'd2;
    localparam logic [4:0] OFS_IE       = 5'd3;
    localparam logic [4:0] OFS_IP       = 5'd4;
    localparam logic [4:0] OFS_ITYPE_LO = 5'd5;
    localparam logic [4:0] OFS_ITYPE_HI = 5'd6;
    localparam logic [4:0] OFS_DB       = 5'd7;
    localparam logic [4:0] OFS_OUT_SET  = 5'd8;
    localparam logic [4:0] OFS_OUT_CLR  = 5'd9;

    typedef enum logic [1:0] {
        ITYPE_BOTH  = 2'b00,
        ITYPE_RISE  = 2'b01,
        ITYPE_FALL  = 2'b10,
        ITYPE_LEVEL = 2'b11
    } itype_e;

    // Level mode reports an event on every cycle the filtered input is high,
    // which is what keeps a level-triggered pending bit from being cleared.
    function automatic logic pin_event(input itype_e mode,
                                       input logic   filt,
                                       input logic   filt_q);
        logic ev;
        ev = 1'b0;
        case (mode)
            ITYPE_BOTH:  ev = filt ^ filt_q;
            ITYPE_RISE:  ev = filt & ~filt_q;
            ITYPE_FALL:  ev = ~filt & filt_q;
            ITYPE_LEVEL: ev = filt;
            default:     ev = 1'b0;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin input conditioner: two-flop synchroniser followed by a debounce
// counter. The filtered level only follows the synchronised input after it has
// disagreed with the filtered level for db+1 consecutive cycles.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   pin       - asynchronous pin input
//   db        - debounce count shared by all pins
//   db_clr    - pulses when db is written; restarts the count, keeps filt
//   filt      - debounced pin level
module gpio_debounce (
    input  logic       clk,
    input  logic       rst,
    input  logic       pin,
    input  logic [7:0] db,
    input  logic       db_clr,
    output logic       filt
);

    logic       in0;
    logic       in1;
    logic [7:0] cnt;

    // Synchroniser and debounce counter. A count in progress is abandoned as
    // soon as the input agrees with filt again, so glitches shorter than db+1
    // cycles never reach filt.
    always_ff @(posedge clk) begin
        if (rst) begin
            in0  <= 1'b0;
            in1  <= 1'b0;
            filt <= 1'b0;
            cnt  <= 8'd0;
        end else begin
            in0 <= pin;
            in1 <= in0;
            if (db_clr) begin
                cnt <= 8'd0;
            end else if (in1 == filt) begin
                cnt <= 8'd0;
            end else if (cnt == db) begin
                filt <= in1;
                cnt  <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/gpio_irqmode.sv
// GPIO block with per-pin debounced inputs and configurable edge/level
// interrupts, controlled through a 10-register CSR window at BASE_ADDR.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   csr_a    - CSR address (offset decoded modulo 32 from BASE_ADDR)
//   csr_di   - CSR write data
//   csr_we   - CSR write strobe
//   csr_do   - CSR read data, combinational from csr_a
//   in       - asynchronous pin inputs
//   out, oe  - registered pin output values and output enables
//   irq      - registered level interrupt, |(ip & ie) delayed one cycle
module gpio_irqmode #(
    parameter logic [4:0]           BASE_ADDR = 5'h00,
    parameter int                   NUM_GPIOS = 8,
    parameter logic [NUM_GPIOS-1:0] DFL_STATE = '0,
    parameter logic [NUM_GPIOS-1:0] DFL_OE    = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           csr_a,
    input  logic [7:0]           csr_di,
    input  logic                 csr_we,
    output logic [7:0]           csr_do,
    input  logic [NUM_GPIOS-1:0] in,
    output logic [NUM_GPIOS-1:0] out,
    output logic [NUM_GPIOS-1:0] oe,
    output logic                 irq
);

    import gpio_irqmode_pkg::*;

    logic [4:0]           offset;
    logic [NUM_GPIOS-1:0] wdata;
    logic [NUM_GPIOS-1:0] ie;
    logic [NUM_GPIOS-1:0] ip;
    logic [NUM_GPIOS-1:0] itype_lo;
    logic [NUM_GPIOS-1:0] itype_hi;
    logic [7:0]           db;
    logic [NUM_GPIOS-1:0] filt;
    logic [NUM_GPIOS-1:0] filt_q;
    logic [NUM_GPIOS-1:0] ev;
    logic [NUM_GPIOS-1:0] ip_clr;
    logic                 db_we;

    // Subtracting the base lets the window wrap around the top of the 5-bit space.
    assign offset = csr_a - BASE_ADDR;
    assign wdata  = csr_di[NUM_GPIOS-1:0];
    assign db_we  = csr_we && (offset == OFS_DB);
    assign ip_clr = (csr_we && (offset == OFS_IP)) ? wdata : '0;

    for (genvar g = 0; g < NUM_GPIOS; g++) begin : g_pin
        gpio_debounce u_debounce (
            .clk    (clk),
            .rst    (rst),
            .pin    (in[g]),
            .db     (db),
            .db_clr (db_we),
            .filt   (filt[g])
        );
    end

    // Writable configuration and output registers. OUT_SET/OUT_CLR modify
    // only the bits written as 1, leaving the rest of out untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            out      <= DFL_STATE;
            oe       <= DFL_OE;
            ie       <= '0;
            itype_lo <= '0;
            itype_hi <= '0;
            db       <= 8'd0;
        end else if (csr_we) begin
            case (offset)
                OFS_OE:       oe       <= wdata;
                OFS_OUT:      out      <= wdata;
                OFS_IE:       ie       <= wdata;
                OFS_ITYPE_LO: itype_lo <= wdata;
                OFS_ITYPE_HI: itype_hi <= wdata;
                OFS_DB:       db       <= csr_di;
                OFS_OUT_SET:  out      <= out | wdata;
                OFS_OUT_CLR:  out      <= out & ~wdata;
                default:      ;
            endcase
        end
    end

    // Per-pin event according to the configured interrupt type.
    always_comb begin
        ev = '0;
        for (int i = 0; i < NUM_GPIOS; i++) begin
            ev[i] = pin_event(itype_e'({itype_hi[i], itype_lo[i]}), filt[i], filt_q[i]);
        end
    end

    // Pending bits and interrupt output. A set event is ORed in after the W1C
    // mask so it wins over a simultaneous clear; irq looks at the registered ip.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= '0;
            ip     <= '0;
            irq    <= 1'b0;
        end else begin
            filt_q <= filt;
            ip     <= (ip & ~ip_clr) | ev;
            irq    <= |(ip & ie);
        end
    end

    // CSR read mux; unused upper bits and unmapped offsets read as zero.
    always_comb begin
        csr_do = 8'h00;
        case (offset)
            OFS_OE:       csr_do = 8'(oe);
            OFS_OUT:      csr_do = 8'(out);
            OFS_IN:       csr_do = 8'(filt);
            OFS_IE:       csr_do = 8'(ie);
            OFS_IP:       csr_do = 8'(ip);
            OFS_ITYPE_LO: csr_do = 8'(itype_lo);
            OFS_ITYPE_HI: csr_do = 8'(itype_hi);
            OFS_DB:       csr_do = db;
            OFS_OUT_SET:  csr_do = 8'(out);
            OFS_OUT_CLR:  csr_do = 8'(out);
            default:      csr_do = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_gpio_irqmode.sv
// Directed self-checking bench for gpio_irqmode. A full-width instance at
// base 0 exercises the main function; a 3-pin instance at base 0x1C exercises
// narrow builds and address wrap. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_gpio_irqmode;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;
    logic [7:0] in_pins;
    logic [7:0] out_pins;
    logic [7:0] oe_pins;
    logic       irq;

    logic [4:0] csr3_a;
    logic [7:0] csr3_di;
    logic       csr3_we;
    logic [7:0] csr3_do;
    logic [2:0] in3_pins;
    logic [2:0] out3_pins;
    logic [2:0] oe3_pins;
    logic       irq3;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    gpio_irqmode #(
        .BASE_ADDR (5'h00),
        .NUM_GPIOS (8),
        .DFL_STATE (8'h5A),
        .DFL_OE    (8'hC3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .csr_a  (csr_a),
        .csr_di (csr_di),
        .csr_we (csr_we),
        .csr_do (csr_do),
        .in     (in_pins),
        .out    (out_pins),
        .oe     (oe_pins),
        .irq    (irq)
    );

    gpio_irqmode #(
        .BASE_ADDR (5'h1C),
        .NUM_GPIOS (3),
        .DFL_STATE (3'b010),
        .DFL_OE    (3'b101)
    ) dut3 (
        .clk    (clk),
        .rst    (rst),
        .csr_a  (csr3_a),
        .csr_di (csr3_di),
        .csr_we (csr3_we),
        .csr_do (csr3_do),
        .in     (in3_pins),
        .out    (out3_pins),
        .oe     (oe3_pins),
        .irq    (irq3)
    );

    // Bus helpers: called just after a falling edge, a write spans exactly one rising edge.
    task automatic csr_write(input logic [4:0] a, input logic [7:0] d);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        @(negedge clk);
        csr_we = 1'b0;
    endtask

    task automatic csr_read(input logic [4:0] a, output logic [7:0] d);
        csr_a = a;
        #1;
        d = csr_do;
    endtask

    task automatic csr3_write(input logic [4:0] a, input logic [7:0] d);
        csr3_a  = a;
        csr3_di = d;
        csr3_we = 1'b1;
        @(negedge clk);
        csr3_we = 1'b0;
    endtask

    task automatic csr3_read(input logic [4:0] a, output logic [7:0] d);
        csr3_a = a;
        #1;
        d = csr3_do;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic [7:0] exp_tbl [10];
        exp_tbl = '{8'hC3, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h5A};
        for (int i = 0; i < 10; i++) begin
            csr_read(5'(i), d);
            tests_run++;
            if (d !== exp_tbl[i]) begin
                tests_failed++;
                $display("[TB] FAIL reset_read_ofs%0d: got %h, expected %h", i, d, exp_tbl[i]);
            end
        end
        csr_read(5'h0A, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL unmapped_read: got %h, expected 00", d);
        end
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_irq: got %b, expected 0", irq);
        end
        tests_run++;
        if (out_pins !== 8'h5A || oe_pins !== 8'hC3) begin
            tests_failed++;
            $display("[TB] FAIL reset_pins: got out=%h oe=%h, expected out=5a oe=c3", out_pins, oe_pins);
        end
    endtask

    task automatic test_latency();
        logic [7:0] d;
        @(negedge clk);
        csr_write(5'd5, 8'h00);
        csr_write(5'd6, 8'h00);
        csr_write(5'd3, 8'h01);
        csr_read(5'd3, d);
        tests_run++;
        if (d !== 8'h01) begin
            tests_failed++;
            $display("[TB] FAIL ie_readback: got %h, expected 01", d);
        end
        @(negedge clk);
        in_pins[0] = 1'b1;
        repeat (2) @(negedge clk);
        csr_read(5'd2, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL in_at_k1: got %h, expected 00", d);
        end
        @(negedge clk);
        csr_read(5'd2, d);
        tests_run++;
        if (d !== 8'h01) begin
            tests_failed++;
            $display("[TB] FAIL in_at_k2: got %h, expected 01", d);
        end
        csr_read(5'd4, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL ip_at_k2: got %h, expected 00", d);
        end
        @(negedge clk);
        csr_read(5'd4, d);
        tests_run++;
        if (d !== 8'h01 || irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ip_at_k3: got ip=%h irq=%b, expected ip=01 irq=0", d, irq);
        end
        @(negedge clk);
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL irq_at_k4: got %b, expected 1", irq);
        end
        @(negedge clk);
        csr_write(5'd4, 8'h01);
        csr_read(5'd4, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL ip_w1c: got %h, expected 00", d);
        end
        @(negedge clk);
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL irq_after_w1c: got %b, expected 0", irq);
        end
        // falling edge of pin 0 raises ip[0] again in both-edge mode
        in_pins[0] = 1'b0;
        repeat (6) @(negedge clk);
        csr_read(5'd4, d);
        tests_run++;
        if (d !== 8'h01) begin
            tests_failed++;
            $display("[TB] FAIL ip_fall_both: got %h, expected 01", d);
        end
        csr_write(5'd3, 8'h00);
        csr_write(5'd4, 8'hFF);
        repeat (2) @(negedge clk);
        csr_read(5'd4, d);
        tests_run++;
        if (d !== 8'h00 || irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL latency_cleanup: got ip=%h irq=%b, expected ip=00 irq=0", d, irq);
        end
    endtask

    task automatic test_debounce();
        logic [7:0] d;
        @(negedge clk);
        csr_write(5'd7, 8'h05);
        csr_read(5'd7, d);
        tests_run++;
        if (d !== 8'h05) begin
            tests_failed++;
            $display("[TB] FAIL db_readback: got %h, expected 05", d);
        end
        @(negedge clk);
        in_pins[1] = 1'b1;
        repeat (5) @(negedge clk);
        in_pins[1] = 1'b0;
        repeat (12) @(negedge clk);
        csr_read(5'd2, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL glitch_in: got %h, expected 00", d);
        end
        csr_read(5'd4, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL glitch_ip: got %h, expected 00", d);
        end
        @(negedge clk);
        in_pins[1] = 1'b1;
        repeat (6) @(negedge clk);
        in_pins[1] = 1'b0;
        @(negedge clk);
        csr_read(5'd2, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL pulse_in_early: got %h, expected 00", d);
        end
        @(negedge clk);
        csr_read(5'd2, d);
        tests_run++;
        if (d !== 8'h02) begin
            tests_failed++;
            $display("[TB] FAIL pulse_in: got %h, expected 02", d);
        end
        @(negedge clk);
        csr_read(5'd4, d);
        tests_run++;
        if (d !== 8'h02) begin
            tests_failed++;
            $display("[TB] FAIL pulse_ip: got %h, expected 02", d);
        end
        repeat (12) @(negedge clk);
        csr_write(5'd4, 8'hFF);
        csr_write(5'd7, 8'h00);
        csr_read(5'd2, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL pulse_in_settled: got %h, expected 00", d);
        end
    endtask

    task automatic test_itype();
        logic [7:0] d;
        @(negedge clk);
        in_pins[2] = 1'b1;
        repeat (6) @(negedge clk);
        csr_write(5'd4, 8'hFF);
        csr_write(5'd5, 8'h0C);
        csr_write(5'd6, 8'h08);
        csr_read(5'd4, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL itype_start_ip: got %h, expected 00", d);
        end
        in_pins[2] = 1'b0;
        repeat (6) @(negedge clk);
        csr_read(5'd4, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL rise_mode_fall: got %h, expected 00", d);
        end
        in_pins[2] = 1'b1;
        repeat (6) @(negedge clk);
        csr_read(5'd4, d);
        tests_run++;
        if (d !== 8'h04) begin
            tests_failed++;
            $display("[TB] FAIL rise_mode_rise: got %h, expected 04", d);
        end
        csr_write(5'd4, 8'h04);
        in_pins[3] = 1'b1;
        repeat (6) @(negedge clk);
        csr_read(5'd4, d);
        tests_run++;
        if (d !== 8'h08) begin
            tests_failed++;
            $display("[TB] FAIL level_set: got %h, expected 08", d);
        end
        csr_write(5'd4, 8'h08);
        csr_read(5'd4, d);
        tests_run++;
        if (d !== 8'h08) begin
            tests_failed++;
            $display("[TB] FAIL level_sticky: got %h, expected 08", d);
        end
        in_pins[3] = 1'b0;
        repeat (6) @(negedge clk);
        csr_write(5'd4, 8'h08);
        csr_read(5'd4, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL level_clear: got %h, expected 00", d);
        end
    endtask

    task automatic test_out();
        logic [7:0] d;
        @(negedge clk);
        csr_write(5'd1, 8'hF0);
        csr_write(5'd8, 8'h03);
        csr_write(5'd9, 8'h10);
        csr_read(5'd1, d);
        tests_run++;
        if (d !== 8'hE3) begin
            tests_failed++;
            $display("[TB] FAIL out_set_clr: got %h, expected e3", d);
        end
        csr_read(5'd8, d);
        tests_run++;
        if (d !== 8'hE3 || out_pins !== 8'hE3) begin
            tests_failed++;
            $display("[TB] FAIL out_pins: got read=%h pins=%h, expected e3", d, out_pins);
        end
    endtask

    task automatic test_reset_midevent();
        logic [7:0] d;
        @(negedge clk);
        in_pins = 8'h00;
        repeat (6) @(negedge clk);
        csr_write(5'd4, 8'hFF);
        in_pins[4] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        csr_read(5'd4, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_ip: got %h, expected 00", d);
        end
        csr_read(5'd2, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_in: got %h, expected 00", d);
        end
        repeat (5) @(negedge clk);
        csr_read(5'd4, d);
        tests_run++;
        if (d !== 8'h10) begin
            tests_failed++;
            $display("[TB] FAIL held_high_rise: got %h, expected 10", d);
        end
    endtask

    task automatic test_narrow_build();
        logic [7:0] d;
        pulse_reset();
        csr3_read(5'h1C, d);
        tests_run++;
        if (d !== 8'h05) begin
            tests_failed++;
            $display("[TB] FAIL narrow_oe_default: got %h, expected 05", d);
        end
        csr3_write(5'h1C, 8'hFF);
        csr3_read(5'h1C, d);
        tests_run++;
        if (d !== 8'h07 || oe3_pins !== 3'b111) begin
            tests_failed++;
            $display("[TB] FAIL narrow_oe: got read=%h oe=%b, expected read=07 oe=111", d, oe3_pins);
        end
        csr3_write(5'h1D, 8'hFF);
        csr3_read(5'h1D, d);
        tests_run++;
        if (d !== 8'h07) begin
            tests_failed++;
            $display("[TB] FAIL narrow_out: got %h, expected 07", d);
        end
        // offset 6 (ITYPE_HI) wraps to address 0x02
        csr3_write(5'h02, 8'h05);
        csr3_read(5'h02, d);
        tests_run++;
        if (d !== 8'h05) begin
            tests_failed++;
            $display("[TB] FAIL wrap_itype_hi: got %h, expected 05", d);
        end
        csr3_read(5'h06, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL narrow_unmapped: got %h, expected 00", d);
        end
    endtask

    initial begin
        rst      = 1'b1;
        csr_a    = 5'd0;
        csr_di   = 8'h00;
        csr_we   = 1'b0;
        in_pins  = 8'h00;
        csr3_a   = 5'd0;
        csr3_di  = 8'h00;
        csr3_we  = 1'b0;
        in3_pins = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_latency();
        test_debounce();
        test_itype();
        test_out();
        test_reset_midevent();
        test_narrow_build();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gpio_irqmode.md
GPIO_IRQMODE -- requirements
Module: gpio_irqmode

Interface
REQ-001 Parameter BASE_ADDR, default 5'h00: base of this block's CSR window.
REQ-002 Parameter NUM_GPIOS, default 8: pin count, legal range 1..8.
REQ-003 Parameter DFL_STATE, default all-0: reset value of out.
REQ-004 Parameter DFL_OE, default all-0: reset value of oe.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 csr_a  in  5  CSR address.
REQ-008 csr_di  in  8  CSR write data.
REQ-009 csr_we  in  1  CSR write strobe, one write per asserted cycle.
REQ-010 csr_do  out  8  CSR read data, combinational from csr_a.
REQ-011 in  in  NUM_GPIOS  asynchronous pin inputs.
REQ-012 out  out  NUM_GPIOS  registered pin output values.
REQ-013 oe  out  NUM_GPIOS  registered pin output enables.
REQ-014 irq  out  1  registered, level-sensitive interrupt request.

Function
REQ-015 Each register offset N is decoded as csr_a == BASE_ADDR+N, with 5-bit wrap. The offsets are:
- +0 OE: RW.
- +1 OUT: RW.
- +2 IN: RO, filtered value.
- +3 IE: RW.
- +4 IP: read, write-1-to-clear.
- +5 ITYPE_LO: RW.
- +6 ITYPE_HI: RW.
- +7 DB: RW, 8-bit debounce count.
- +8 OUT_SET: write sets the written 1-bits of out; reads return OUT.
- +9 OUT_CLR: write clears the written 1-bits of out; reads return OUT.
REQ-016 Unmapped addresses read 8'h00 and ignore writes; bits NUM_GPIOS..7 read 0 and ignore writes; DB uses all 8 bits.
REQ-017 Input path per pin: two-flop synchroniser (in0, in1), then a debounce stage holding filt and an 8-bit cnt.
REQ-018 Debounce stage, per pin per cycle:
- If in1 == filt: cnt <= 0.
- Else if cnt == DB: filt <= in1 and cnt <= 0.
- Else: cnt <= cnt+1.
REQ-019 A new pin level therefore reaches filt only after DB+1 consecutive mismatching cycles; DB=0 gives a filt update one cycle after in1.
REQ-020 A write to DB clears every cnt in the same cycle; filt values are retained.
REQ-021 Event detection uses filt and its one-cycle delay filt_q:
- rise = filt & ~filt_q.
- fall = ~filt & filt_q.
REQ-022 Mode per pin is {ITYPE_HI[i], ITYPE_LO[i]}:
- 00: both edges.
- 01: rising edge.
- 10: falling edge.
- 11: level-high, meaning the event is filt==1 on every cycle.
REQ-023 ip[i] is set on the clock edge following an event of the pin's configured mode, independent of ie.
REQ-024 A W1C write to IP clears the written bits; if a set event and a clear coincide on the same bit, the set wins.
REQ-025 A level-mode pin whose filt stays high cannot be cleared.
REQ-026 Writing ITYPE or IE leaves ip unchanged.
REQ-027 irq <= |(ip & ie) every cycle, so irq follows ip/ie with one cycle of latency and stays asserted until serviced.
REQ-028 Latency with DB=0: a pin change captured by in0 at edge k reaches IN readback at k+2, sets ip at k+3 and asserts irq at k+4.
REQ-029 Write priority on out: a write to OUT, OUT_SET or OUT_CLR affects only that cycle (one address per cycle).

Reset
REQ-030 On rst, the following take these values: out=DFL_STATE, oe=DFL_OE, irq=0, and ie, ip, ITYPE, DB, in0, in1, filt, filt_q and all cnt = 0.
REQ-031 rst asserted mid-debounce or mid-event discards the pending count and event; no ip bit is set on the cycle after rst deasserts.
REQ-032 A pin held high through reset produces a rise event once filt reaches 1; this is intended behaviour.

Structure
REQ-033 Register offsets (0..9) and ITYPE encodings live in the shared gpio definitions package/include used by all gpio-family blocks.
REQ-034 Sub-module gpio_debounce (one pin: synchroniser, cnt, filt) is instantiated NUM_GPIOS times via generate.
REQ-035 Event/IP/IRQ logic and CSR decode stay in gpio_irqmode.

Verification
REQ-036 Apply rst, then read all offsets: OE=DFL_OE, OUT=DFL_STATE, others 0; irq=0.
REQ-037 With DB=0, ITYPE=00 and IE=8'h01, toggle in[0] 0->1: IN bit0=1 at k+2, IP=8'h01 at k+3, irq=1 at k+4. Write IP=8'h01: IP=0 and irq=0 one cycle later.
REQ-038 With DB=5, a 5-cycle glitch on in[1] leaves IN and IP unchanged; a 6-cycle pulse sets filt after 6 mismatching cycles.
REQ-039 With pin2 in mode 01: a falling edge sets no ip bit and a rising edge sets ip[2]. With pin3 in mode 11 held high: a W1C to ip[3] leaves it set; after in[3] drops and filt follows, the W1C clears it.
REQ-040 OUT=8'hF0, OUT_SET=8'h03, then OUT_CLR=8'h10: OUT reads 8'hE3.
REQ-041 Build with NUM_GPIOS=3 and write 8'hFF to OE: the read returns 8'h07 and oe=3'b111.
